// File: rtl/fb_access_ctrl.sv
// Framebuffer access controller: arbitrates clear engine vs. drawing writes
// and generates the sequential display scan-out read stream.
module fb_access_ctrl #(
  parameter int unsigned         ADDR_W    = 11,
  parameter int unsigned         DATA_W    = 6,
  parameter logic [DATA_W-1:0]   CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              wr_ack,
  input  logic              scan_en,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              frame_start,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [DATA_W-1:0] fb_wr_data,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [DATA_W-1:0] fb_rd_data
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_nxt;
  logic [ADDR_W-1:0] r_scan_cnt;
  logic [ADDR_W-1:0] r_rd_addr_d;
  logic              r_pix_valid;
  logic              w_wr_en;
  logic              w_wr_ack;
  logic              w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = '0;
    w_busy        = 1'b0;
    w_wr_en       = 1'b0;
    w_wr_ack      = 1'b0;
    fb_wr_addr    = wr_req_addr;
    fb_wr_data    = wr_req_data;
    case (r_state)
      S_IDLE: begin
        w_wr_en  = wr_req;
        w_wr_ack = wr_req;
        if (clr_start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_busy     = 1'b1;
        w_wr_en    = 1'b1;
        fb_wr_addr = r_clr_cnt;
        fb_wr_data = CLEAR_VAL;
        // A new request mid-clear restarts the sweep from address 0.
        if (clr_start)            w_clr_cnt_nxt = '0;
        else if (r_clr_cnt == '1) w_state_nxt   = S_IDLE;
        else                      w_clr_cnt_nxt = r_clr_cnt + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write strobes are gated by rst_n so reset silences the RAM port at once.
  assign fb_wr_en = w_wr_en  & rst_n;
  assign wr_ack   = w_wr_ack & rst_n;
  assign clr_busy = w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt  <= '0;
      r_rd_addr_d <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_pix_valid <= scan_en;
      r_rd_addr_d <= r_scan_cnt;
      if (scan_en) r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign fb_rd_addr  = r_scan_cnt;
  assign pix_valid   = r_pix_valid;
  assign pix_data    = fb_rd_data;
  assign frame_start = r_pix_valid && (r_rd_addr_d == '0);

endmodule

// File: tb/tb_fb_access_ctrl.sv
// Directed bench for fb_access_ctrl with a read-before-write RAM model.
module tb_fb_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_start;
  logic        clr_busy;
  logic        wr_req;
  logic [10:0] wr_req_addr;
  logic [5:0]  wr_req_data;
  logic        wr_ack;
  logic        scan_en;
  logic [5:0]  pix_data;
  logic        pix_valid;
  logic        frame_start;
  logic        fb_wr_en;
  logic [10:0] fb_wr_addr;
  logic [5:0]  fb_wr_data;
  logic [10:0] fb_rd_addr;
  logic [5:0]  fb_rd_data;

  logic [5:0]  mem [0:2047];
  logic [5:0]  rd_q;
  logic        fill_req;
  logic [5:0]  fill_val;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fb_access_ctrl #(
    .ADDR_W   (11),
    .DATA_W   (6),
    .CLEAR_VAL(6'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .wr_req     (wr_req),
    .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data),
    .wr_ack     (wr_ack),
    .scan_en    (scan_en),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .fb_wr_en   (fb_wr_en),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_data (fb_wr_data),
    .fb_rd_addr (fb_rd_addr),
    .fb_rd_data (fb_rd_data)
  );

  // RAM: one-cycle read latency, old data returned on same-address write.
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 2048; i++) mem[i] <= fill_val;
    end else if (fb_wr_en) begin
      mem[fb_wr_addr] <= fb_wr_data;
    end
    rd_q <= mem[fb_rd_addr];
  end
  assign fb_rd_data = rd_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pixel(input int a);
    case (a)
      5:       return 6'h2A;
      100:     return 6'h0C;
      101:     return 6'h0D;
      default: return 6'h00;
    endcase
  endfunction

  initial begin
    int n;
    int bad;
    int acks;
    int fs_cnt;
    int fs_bad;
    int pv_bad;
    int pix_bad;
    logic [5:0] pix5;

    rst_n = 1'b0; clr_start = 1'b0; wr_req = 1'b0; wr_req_addr = '0;
    wr_req_data = '0; scan_en = 1'b0; fill_req = 1'b0; fill_val = '0;

    // Reset state, with a write request pending that must not reach the RAM
    #2;
    wr_req = 1'b1; wr_req_addr = 11'd9; wr_req_data = 6'h03;
    #1;
    check("rst_busy",   clr_busy,    0);
    check("rst_ack",    wr_ack,      0);
    check("rst_wr_en",  fb_wr_en,    0);
    check("rst_pv",     pix_valid,   0);
    check("rst_fs",     frame_start, 0);
    check("rst_rdaddr", fb_rd_addr,  0);
    wr_req = 1'b0;
    fill_val = 6'h15; fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First write after reset is granted on the first edge
    #2;
    wr_req = 1'b1; wr_req_addr = 11'd7; wr_req_data = 6'h09;
    #1;
    check("wr_ack",   wr_ack,     1);
    check("wr_en",    fb_wr_en,   1);
    check("wr_addr",  fb_wr_addr, 7);
    check("wr_data",  fb_wr_data, 6'h09);
    tick();
    wr_req = 1'b0;
    #1;
    check("wr_ack_pulse", wr_ack, 0);
    check("wr_mem7",      mem[7], 6'h09);
    check("wr_mem8",      mem[8], 6'h15);

    // Full clear
    clr_start = 1'b1;
    #1;
    check("clr_busy_idle", clr_busy, 0);
    tick();
    clr_start = 1'b0;
    n = 0; bad = 0;
    while (clr_busy === 1'b1 && n < 3000) begin
      if (fb_wr_en !== 1'b1 || fb_wr_addr !== n[10:0] || fb_wr_data !== 6'h00) bad++;
      n++;
      tick();
    end
    check("clr_len",     n,         2048);
    check("clr_seq",     bad,       0);
    check("clr_mem0",    mem[0],    0);
    check("clr_mem7",    mem[7],    0);
    check("clr_mem2047", mem[2047], 0);

    // Simultaneous clr_start and write in IDLE
    clr_start = 1'b1; wr_req = 1'b1; wr_req_addr = 11'd3; wr_req_data = 6'h11;
    #1;
    check("sim_ack",  wr_ack,     1);
    check("sim_addr", fb_wr_addr, 3);
    check("sim_busy0", clr_busy,  0);
    tick();
    clr_start = 1'b0; wr_req = 1'b0;
    #1;
    check("sim_busy1",  clr_busy,   1);
    check("sim_ack1",   wr_ack,     0);
    check("sim_addr0",  fb_wr_addr, 0);
    check("sim_mem3w",  mem[3],     6'h11);
    n = 0;
    while (clr_busy === 1'b1 && n < 3000) begin
      n++;
      tick();
    end
    check("sim_len",   n,      2048);
    check("sim_mem3c", mem[3], 0);

    // Write held from clear cycle 10, restart at clear cycle 20
    clr_start = 1'b1;
    #1;
    tick();
    clr_start = 1'b0;
    n = 0; acks = 0;
    while (clr_busy === 1'b1 && n < 3000) begin
      if (n == 10) begin
        wr_req = 1'b1; wr_req_addr = 11'd5; wr_req_data = 6'h2A;
      end
      if (n == 20) clr_start = 1'b1;
      if (n == 21) clr_start = 1'b0;
      #1;
      if (n == 21) check("restart_addr", fb_wr_addr, 0);
      if (wr_ack === 1'b1) acks++;
      n++;
      @(posedge clk);
      #1;
    end
    check("wdc_len",  n,    2069);
    check("wdc_acks", acks, 0);
    #1;
    check("wdc_ack",  wr_ack,     1);
    check("wdc_addr", fb_wr_addr, 5);
    tick();
    wr_req = 1'b0;
    #1;
    check("wdc_ack_pulse", wr_ack, 0);
    check("wdc_mem5",      mem[5], 6'h2A);

    // Markers at 100/101 for the pause test
    wr_req = 1'b1; wr_req_addr = 11'd100; wr_req_data = 6'h0C;
    tick();
    wr_req_addr = 11'd101; wr_req_data = 6'h0D;
    tick();
    wr_req = 1'b0;

    // Scan wrap: frame_start at cycles 1, 2049, 4097
    scan_en = 1'b1;
    fs_cnt = 0; fs_bad = 0; pv_bad = 0; pix_bad = 0; pix5 = '0;
    for (int t = 1; t <= 4196; t++) begin
      tick();
      if (pix_valid !== 1'b1) pv_bad++;
      if (frame_start !== ((t == 1) || (t == 2049) || (t == 4097))) fs_bad++;
      if (frame_start === 1'b1) fs_cnt++;
      if (pix_data !== pixel((t - 1) % 2048)) pix_bad++;
      if (t == 6) pix5 = pix_data;
    end
    check("scan_pv",     pv_bad,  0);
    check("scan_fs",     fs_bad,  0);
    check("scan_fs_cnt", fs_cnt,  3);
    check("scan_pix",    pix_bad, 0);
    check("scan_pix5",   pix5,    6'h2A);
    check("scan_addr100", fb_rd_addr, 100);

    // Scan pause at address 100
    scan_en = 1'b0;
    pv_bad = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (pix_valid !== 1'b0) pv_bad++;
    end
    check("pause_pv",   pv_bad,     0);
    check("pause_addr", fb_rd_addr, 100);
    scan_en = 1'b1;
    tick();
    check("resume_pv",    pix_valid,   1);
    check("resume_pix0",  pix_data,    6'h0C);
    check("resume_fs",    frame_start, 0);
    tick();
    check("resume_pix1",  pix_data,    6'h0D);
    scan_en = 1'b0;

    // Reset at clear cycle 500
    fill_val = 6'h2B; fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    clr_start = 1'b1;
    #1;
    tick();
    clr_start = 1'b0;
    repeat (500) tick();
    check("rmc_addr", fb_wr_addr, 500);
    rst_n = 1'b0;
    #1;
    check("rmc_wr_en", fb_wr_en, 0);
    check("rmc_busy",  clr_busy, 0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (4) begin
      tick();
      if (fb_wr_en !== 1'b0 || clr_busy !== 1'b0) bad++;
    end
    check("rmc_quiet",   bad,       0);
    check("rmc_mem0",    mem[0],    0);
    check("rmc_mem499",  mem[499],  0);
    check("rmc_mem500",  mem[500],  6'h2B);
    check("rmc_mem2047", mem[2047], 6'h2B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
